// File: rtl/comparator_bist_if.sv
// comparator_bist_if
//   Connection between the BIST engine and the combinational comparator it
//   exercises.
//   master (BIST side): drives test_a/test_b, receives dut_eq/dut_lt/dut_gt.
//   slave  (comparator side): receives the operands, drives the three flags.
interface comparator_bist_if #(
  parameter int WIDTH = 4
) ();

  logic [WIDTH-1:0] test_a;
  logic [WIDTH-1:0] test_b;
  logic             dut_eq;
  logic             dut_lt;
  logic             dut_gt;

  modport master (
    output test_a,
    output test_b,
    input  dut_eq,
    input  dut_lt,
    input  dut_gt
  );

  modport slave (
    input  test_a,
    input  test_b,
    output dut_eq,
    output dut_lt,
    output dut_gt
  );

endinterface

// File: rtl/comparator_bist.sv
// comparator_bist
//   Exhaustive built-in self-test for a combinational magnitude comparator.
//   The engine sweeps every {a,b} operand pair, with b varying fastest. It
//   spends one cycle driving each vector and one cycle checking the returned
//   flags against a golden unsigned comparison. It then reports pass/fail, a
//   saturating mismatch count and the first failing vector.
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a sweep (honoured only in IDLE or DONE)
//   cmp        comparator_bist_if.master: test_a/test_b out, eq/lt/gt flags in
//   busy       high while a sweep is running
//   done       high from sweep completion until the next start or reset
//   pass       valid with done; 1 when no mismatches were seen
//   err_count  mismatching vector count, saturating at all-ones
//   fail_a     operand A of the first mismatching vector (0 if none)
//   fail_b     operand B of the first mismatching vector (0 if none)
module comparator_bist #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  comparator_bist_if.master    cmp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b
);

  localparam int CW = 2 * WIDTH;
  localparam int EW = 2 * WIDTH + 1;

  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] ERR_ZERO = '0;
  localparam logic [EW-1:0] ERR_MAX  = '1;
  localparam logic [EW-1:0] ERR_ONE  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] OP_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;       // {a,b}; b in the low half so it varies fastest
  logic [EW-1:0]    err_q;
  logic [WIDTH-1:0] fail_a_q;
  logic [WIDTH-1:0] fail_b_q;
  logic             first_q;     // a mismatch has already been latched
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] op_b_s;
  logic [2:0]       exp_flags_s;
  logic [2:0]       got_flags_s;
  logic             mismatch_s;
  logic             last_s;
  logic [EW-1:0]    err_d;
  logic [CW-1:0]    cnt_d;

  assign op_a_s = cnt_q[CW-1:WIDTH];
  assign op_b_s = cnt_q[WIDTH-1:0];

  // Golden comparison, mismatch detection and next counter values
  always_comb begin
    exp_flags_s = {(op_a_s == op_b_s), (op_a_s < op_b_s), (op_a_s > op_b_s)};
    got_flags_s = {cmp.dut_eq, cmp.dut_lt, cmp.dut_gt};
    // A vector counts once no matter how many flags are wrong. This covers
    // the all-zero and multi-hot patterns.
    mismatch_s  = (got_flags_s != exp_flags_s);
    last_s      = (cnt_q == CNT_MAX);
    cnt_d       = cnt_q + CNT_ONE;
    if (mismatch_s && (err_q != ERR_MAX)) begin
      err_d = err_q + ERR_ONE;
    end else begin
      err_d = err_q;
    end
  end

  // Sweep sequencer with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      err_q    <= ERR_ZERO;
      fail_a_q <= OP_ZERO;
      fail_b_q <= OP_ZERO;
      first_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // In DONE the last vector stays on test_a/test_b until a restart.
          if (start) begin
            state_q  <= ST_DRIVE;
            cnt_q    <= CNT_ZERO;
            err_q    <= ERR_ZERO;
            fail_a_q <= OP_ZERO;
            fail_b_q <= OP_ZERO;
            first_q  <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
          end
        end
        ST_DRIVE: begin
          // Operands are already on the bus; give the comparator a cycle.
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          err_q <= err_d;
          if (mismatch_s && !first_q) begin
            fail_a_q <= op_a_s;
            fail_b_q <= op_b_s;
            first_q  <= 1'b1;
          end
          // The terminal test on all-ones stops the counter before it wraps.
          // As a result the (max,max) vector is checked exactly once.
          if (last_s) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == ERR_ZERO);
          end else begin
            cnt_q   <= cnt_d;
            state_q <= ST_DRIVE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmp.test_a = op_a_s;
  assign cmp.test_b = op_b_s;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;

endmodule

// File: tb/tb_comparator_bist.sv
// tb_comparator_bist
//   Drives comparator_bist against a behavioural comparator that can carry
//   injected faults. It predicts err_count, pass and the first failing vector
//   by enumerating all operand pairs in sweep order, then checks the engine's
//   report, its 512-cycle latency, vector ordering, reset abort and restart.
module tb_comparator_bist;

  localparam int W  = 4;
  localparam int NV = 1 << (2 * W);

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [2*W:0]     err_count;
  logic [W-1:0]     fail_a;
  logic [W-1:0]     fail_b;

  int total = 0;
  int bad   = 0;

  // Fault model of the comparator under test
  int         fault_mode;
  logic [2:0] flip_mask [NV];
  logic [2:0] flags_s;

  comparator_bist_if #(.WIDTH(W)) cif ();

  comparator_bist #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cmp       (cif.master),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_a    (fail_a),
    .fail_b    (fail_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] golden(input int a, input int b);
    return {a == b, a < b, a > b};
  endfunction

  // Modes: 0 good, 1 eq stuck-at-0, 2 lt/gt swapped,
  //        3 all flags high only at (5,5), 4 random flips, 5 all flags low
  function automatic logic [2:0] faulty(input int mode, input int a, input int b,
                                        input logic [2:0] mask);
    logic [2:0] g;
    g = golden(a, b);
    case (mode)
      1:       return {1'b0, g[1], g[0]};
      2:       return {g[2], g[0], g[1]};
      3:       return (a == 5 && b == 5) ? 3'b111 : g;
      4:       return g ^ mask;
      5:       return 3'b000;
      default: return g;
    endcase
  endfunction

  always_comb begin
    flags_s = faulty(fault_mode, int'(cif.test_a), int'(cif.test_b),
                     flip_mask[{cif.test_a, cif.test_b}]);
  end

  assign cif.dut_eq = flags_s[2];
  assign cif.dut_lt = flags_s[1];
  assign cif.dut_gt = flags_s[0];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run_sweep(input int mode, input bit inject);
    int n;
    int exp_err;
    int exp_fa;
    int exp_fb;
    bit found;
    int seq[$];
    int cur;
    int last;
    int bad_order;

    fault_mode = mode;
    for (int i = 0; i < NV; i++) begin
      if (mode == 4) begin
        flip_mask[i] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      end else begin
        flip_mask[i] = 3'b000;
      end
    end

    // Reference: enumerate A outer, B inner, the order the sweep visits them
    exp_err = 0; exp_fa = 0; exp_fb = 0; found = 1'b0;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        if (faulty(mode, a, b, flip_mask[a * (1 << W) + b]) != golden(a, b)) begin
          exp_err++;
          if (!found) begin
            found = 1'b1; exp_fa = a; exp_fb = b;
          end
        end
      end
    end

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("busy_on_start", busy, 1);
    check_val("done_cleared", done, 0);
    check_val("err_cleared", err_count, 0);
    check_val("fail_cleared", {fail_a, fail_b}, 0);

    n = 0;
    last = -1;
    while (!done && n < 2000) begin
      cur = int'({cif.test_a, cif.test_b});
      if (cur != last) seq.push_back(cur);
      last = cur;
      if (inject) start = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;

    bad_order = (seq.size() != NV) ? 1 : 0;
    for (int i = 0; i < seq.size() && i < NV; i++) begin
      if (seq[i] != i) bad_order++;
    end

    check_val("latency", n, 2 * NV);
    check_val("done", done, 1);
    check_val("busy_off", busy, 0);
    check_val("err_count", err_count, exp_err);
    check_val("pass", pass, (exp_err == 0) ? 1 : 0);
    check_val("fail_a", fail_a, exp_fa);
    check_val("fail_b", fail_b, exp_fb);
    check_val("vector_order", bad_order, 0);
    check_val("hold_last_vec", {cif.test_a, cif.test_b}, NV - 1);
    // Two idle cycles in DONE: everything must stay put
    repeat (2) @(posedge clk);
    #1;
    check_val("done_hold", {done, busy, err_count}, {1'b1, 1'b0, 9'(exp_err)});
  endtask

  initial begin
    fault_mode = 0;
    for (int i = 0; i < NV; i++) flip_mask[i] = 3'b000;
    start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_state",
              {busy, done, pass, err_count, fail_a, fail_b, cif.test_a, cif.test_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(0, 1'b0);
    run_sweep(1, 1'b0);
    run_sweep(2, 1'b1);
    run_sweep(3, 1'b0);
    run_sweep(5, 1'b0);
    for (int k = 0; k < 3; k++) run_sweep(4, k[0]);

    // Abort a sweep 100 cycles in with an asynchronous reset
    fault_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("midsweep_reset",
              {busy, done, pass, err_count, fail_a, fail_b, cif.test_a, cif.test_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("idle_after_reset", {busy, done}, 0);
    run_sweep(0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
